// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU path with a buffered long-latency path
// into the register-file write port and tracks pending destinations.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_stall,
  input  logic            i_lsu_valid,
  input  logic [4:0]      i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  output logic            o_lsu_ready,
  output logic            o_Wen,
  output logic [4:0]      o_Wnum,
  output logic [XLEN-1:0] o_Wd,
  output logic [31:0]     o_pend_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      rd_q  [DEPTH];
  logic [XLEN-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q;
  logic [WW-1:0]   wait_q, wait_d;
  logic            wen_q, wen_d;
  logic [4:0]      wnum_q, wnum_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic empty, full, stall, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign stall = (wait_q == WW'(STARVE_LIMIT));
  assign push  = i_lsu_valid && !full;
  // a stall implies a non-empty FIFO, so the head wins
  assign pop   = !empty && (stall || !i_alu_valid);

  always_comb begin
    wen_d  = 1'b0;
    wnum_d = wnum_q;
    wd_d   = wd_q;
    if (pop) begin
      wen_d  = (rd_q[rp_q] != 5'd0);
      wnum_d = rd_q[rp_q];
      wd_d   = dat_q[rp_q];
    end else if (i_alu_valid) begin
      wen_d  = (i_alu_rd != 5'd0);
      wnum_d = i_alu_rd;
      wd_d   = i_alu_data;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (empty || pop)
      wait_d = '0;
    else if (!stall)
      wait_d = wait_q + WW'(1);
  end

  always_comb begin
    vld_d = vld_q;
    if (pop)
      vld_d[rp_q] = 1'b0;
    if (push)
      vld_d[wp_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
      wen_q  <= 1'b0;
      wnum_q <= '0;
      wd_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      wp_q   <= push ? wp_q + AW'(1) : wp_q;
      rp_q   <= pop ? rp_q + AW'(1) : rp_q;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      wait_q <= wait_d;
      wen_q  <= wen_d;
      wnum_q <= wnum_d;
      wd_q   <= wd_d;
    end
  end

  // payload storage needs no reset; vld_q gates every use
  always_ff @(posedge i_clk) begin
    if (push) begin
      rd_q[wp_q]  <= i_lsu_rd;
      dat_q[wp_q] <= i_lsu_data;
    end
  end

  always_comb begin
    o_pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i])
        o_pend_mask[rd_q[i]] = 1'b1;
    if (wen_q)
      o_pend_mask[wnum_q] = 1'b1;
    o_pend_mask[0] = 1'b0;
  end

  assign o_alu_stall = stall;
  assign o_lsu_ready = !full;
  assign o_Wen       = wen_q;
  assign o_Wnum      = wnum_q;
  assign o_Wd        = wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed traffic with a write-port scoreboard
// plus direct checks on stall, ready and pending mask.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        wen;
  logic [4:0]  wnum;
  logic [31:0] wd;
  logic [31:0] pend;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_alu_valid (alu_valid),
    .i_alu_rd    (alu_rd),
    .i_alu_data  (alu_data),
    .o_alu_stall (alu_stall),
    .i_lsu_valid (lsu_valid),
    .i_lsu_rd    (lsu_rd),
    .i_lsu_data  (lsu_data),
    .o_lsu_ready (lsu_ready),
    .o_Wen       (wen),
    .o_Wnum      (wnum),
    .o_Wd        (wd),
    .o_pend_mask (pend)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_w(input logic [4:0] rd, input logic [31:0] d);
    wr_t w;
    w.rd = rd;
    w.d  = d;
    sb.push_back(w);
  endtask

  task automatic alu(input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    lsu_valid = v;
    lsu_rd    = rd;
    lsu_data  = d;
  endtask

  always @(negedge clk) begin
    if (rstn && wen) begin
      if (sb.size() == 0) begin
        chk("unexp_write", {27'd0, wnum}, 64'h0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("wnum", {59'd0, wnum}, {59'd0, w.rd});
        chk("wd", {32'd0, wd}, {32'd0, w.d});
      end
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_wen", wen, 0);
    chk("rst_wnum", wnum, 0);
    chk("rst_wd", wd, 0);
    chk("rst_pend", pend, 0);
    chk("rst_stall", alu_stall, 0);
    chk("rst_ready", lsu_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    // ALU only
    alu(1, 5'd5, 32'hDEADBEEF);
    exp_w(5'd5, 32'hDEADBEEF);
    tick();
    chk("alu_wen", wen, 1);
    chk("alu_pend", pend, 32'h1 << 5);
    alu(0, 5'd0, 32'h0);
    tick();
    chk("alu_wen_off", wen, 0);
    chk("alu_pend_off", pend, 0);

    // rd = 0 from both sources
    alu(1, 5'd0, 32'h5555);
    tick();
    chk("x0_alu_wen", wen, 0);
    alu(0, 5'd0, 32'h0);
    lsu(1, 5'd0, 32'hAAAA);
    tick();
    chk("x0_push_pend", pend, 0);
    chk("x0_push_wen", wen, 0);
    lsu(0, 5'd0, 32'h0);
    tick();
    chk("x0_pop_wen", wen, 0);
    chk("x0_pop_pend", pend, 0);
    tick();
    chk("x0_idle_wen", wen, 0);

    // LSU into idle block
    lsu(1, 5'd7, 32'h1234);
    exp_w(5'd7, 32'h1234);
    tick();
    chk("lsu_n_wen", wen, 0);
    chk("lsu_n_pend", pend, 32'h1 << 7);
    lsu(0, 5'd0, 32'h0);
    tick();
    chk("lsu_n1_wen", wen, 1);
    chk("lsu_n1_pend", pend, 32'h1 << 7);
    tick();
    chk("lsu_done_pend", pend, 0);
    chk("lsu_done_wen", wen, 0);

    // fill with ALU busy; third entry refused until space frees
    lsu(1, 5'd10, 32'hA0);
    for (int k = 0; k < 5; k++) begin
      alu(1, 5'd1, 32'h100 + k);
      exp_w(5'd1, 32'h100 + k);
      tick();
      if (k == 0) lsu(1, 5'd11, 32'hB0);
      if (k == 1) begin
        chk("fill_ready", lsu_ready, 0);
        lsu(1, 5'd12, 32'hC0);
      end
      if (k == 3) chk("fill_nostall", alu_stall, 0);
    end
    chk("fill_stall", alu_stall, 1);
    chk("fill_ready2", lsu_ready, 0);
    alu(1, 5'd1, 32'h105);
    exp_w(5'd10, 32'hA0);
    tick();
    chk("fill_pop_stall", alu_stall, 0);
    chk("fill_pop_ready", lsu_ready, 1);
    chk("fill_refused", pend, (32'h1 << 10) | (32'h1 << 11));
    exp_w(5'd1, 32'h105);
    tick();
    chk("fill_c_in", pend, 32'h2 | (32'h1 << 11) | (32'h1 << 12));
    alu(0, 5'd0, 32'h0);
    lsu(0, 5'd0, 32'h0);
    exp_w(5'd11, 32'hB0);
    exp_w(5'd12, 32'hC0);
    tick();
    tick();
    tick();
    chk("fill_drain", pend, 0);

    // starvation of rd=9
    alu(1, 5'd2, 32'h200);
    lsu(1, 5'd9, 32'h99);
    exp_w(5'd2, 32'h200);
    tick();
    lsu(0, 5'd0, 32'h0);
    for (int k = 1; k < 5; k++) begin
      alu(1, 5'd2, 32'h200 + k);
      exp_w(5'd2, 32'h200 + k);
      tick();
      if (k == 3) chk("starve_early", alu_stall, 0);
    end
    chk("starve_stall", alu_stall, 1);
    chk("starve_pend", pend, (32'h1 << 9) | (32'h1 << 2));
    alu(1, 5'd2, 32'h205);
    exp_w(5'd9, 32'h99);
    tick();
    chk("starve_wnum", wnum, 9);
    chk("starve_clear", alu_stall, 0);
    exp_w(5'd2, 32'h205);
    tick();
    chk("starve_held", wd, 32'h205);
    chk("starve_clear2", alu_stall, 0);
    alu(0, 5'd0, 32'h0);
    tick();

    // reset mid-stream with two buffered entries
    alu(1, 5'd3, 32'h300);
    lsu(1, 5'd20, 32'h2000);
    exp_w(5'd3, 32'h300);
    tick();
    alu(1, 5'd3, 32'h301);
    lsu(1, 5'd21, 32'h2100);
    exp_w(5'd3, 32'h301);
    tick();
    chk("mid_pend", pend, 32'h8 | (32'h1 << 20) | (32'h1 << 21));
    chk("mid_ready", lsu_ready, 0);
    @(negedge clk);
    #1;
    alu(0, 5'd0, 32'h0);
    lsu(0, 5'd0, 32'h0);
    rstn = 1'b0;
    #1;
    chk("mrst_wen", wen, 0);
    chk("mrst_wnum", wnum, 0);
    chk("mrst_wd", wd, 0);
    chk("mrst_pend", pend, 0);
    chk("mrst_ready", lsu_ready, 1);
    chk("mrst_stall", alu_stall, 0);
    tick();
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_wen", wen, 0);
      chk("post_rst_pend", pend, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that sits directly upstream of the register file and drives its write port (write enable, write register number, write data).
- Merges two result sources:
  - the single-cycle ALU path, which always presents one result per cycle;
  - the long-latency path (load/store and mul/div unit), which uses a valid/ready handshake into a small FIFO.
- Drops writes to x0.
- Exports a pending-destination mask so issue logic can detect RAW hazards against results not yet visible in the register file.

Parameters:
- XLEN, 32, data width of results and write data.
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before the ALU is stalled.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_alu_valid  in  1  ALU result present this cycle.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  XLEN  ALU result.
- o_alu_stall  out  1  ALU result not accepted this cycle; upstream holds it.
- i_lsu_valid  in  1  long-latency result offered.
- i_lsu_rd  in  5  long-latency destination register.
- i_lsu_data  in  XLEN  long-latency result.
- o_lsu_ready  out  1  FIFO can accept an entry.
- o_Wen  out  1  register file write enable.
- o_Wnum  out  5  register file write index.
- o_Wd  out  XLEN  register file write data.
- o_pend_mask  out  32  bit r set if a write to xr is buffered or being written this cycle.

Behaviour:
- Reset (i_rstn=0, asynchronous, effective immediately and also mid-operation):
  - FIFO emptied, wait counter cleared.
  - o_Wen=0, o_Wnum=0, o_Wd=0, o_pend_mask=0, o_alu_stall=0, o_lsu_ready=1.
- o_lsu_ready = !full. It depends only on registered state, never on i_lsu_valid.
- LSU push: occurs on a rising edge with i_lsu_valid && o_lsu_ready.
  - While not ready, upstream holds valid, rd and data stable.
- No push-to-output bypass. An entry pushed at edge N is eligible at edge N+1, so the earliest o_Wen is after edge N+1 (2-cycle minimum latency).
- Arbitration, evaluated each cycle, in priority order:
  - (a) if o_alu_stall=1 and FIFO non-empty: pop head; output register ← head.
  - (b) else if i_alu_valid: output register ← ALU result (1-cycle latency).
  - (c) else if FIFO non-empty: pop head; output register ← head.
  - (d) else: o_Wen ← 0; o_Wnum and o_Wd hold their values.
- Output register update: o_Wen ← (selected rd ≠ 0); o_Wnum ← rd; o_Wd ← data.
  - An rd=0 entry is still consumed (ALU accepted or FIFO popped) but produces no write.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped, saturating at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
  - o_alu_stall = (wait counter == STARVE_LIMIT), combinational from registers.
  - The stall lasts exactly the cycle in which the head pops.
- Push and pop in the same cycle:
  - Allowed whenever the FIFO is not full.
  - When full, a push is refused even if a pop occurs that cycle.
  - Count changes by push−pop.
- FIFO order is preserved; pointers wrap modulo DEPTH.
- o_pend_mask:
  - Bit r = 1 if r≠0 and any valid FIFO entry has rd=r, or if o_Wen=1 and o_Wnum=r.
  - Bit 0 is always 0.
  - Combinational from registered state.
- Outstanding-write ordering to the same rd is the issue logic's responsibility, using o_pend_mask. The block never reorders within a source.

Test Plan:
- Reset mid-stream with FIFO holding 2 entries → all outputs return to reset values immediately; o_lsu_ready=1; no write after release until new input.
- ALU-only traffic: alu_valid=1, rd=5, data=0xDEADBEEF at edge N → o_Wen=1, o_Wnum=5, o_Wd=0xDEADBEEF after edge N; o_pend_mask[5]=1 during that cycle only.
- rd=0: ALU rd=0 followed by LSU rd=0 → o_Wen stays 0; the FIFO entry is consumed; o_pend_mask stays 0.
- LSU push rd=7, data=0x1234 into an idle block at edge N → write appears after edge N+1; o_pend_mask[7]=1 from after edge N until the write cycle ends.
- Fill: LSU valid held with ALU busy → o_lsu_ready=0 after 2 pushes; a 3rd push is refused even in a pop cycle; the data order of 3 entries is preserved on the write port.
- Starvation: FIFO holds rd=9 with ALU continuously valid → after 4 losing cycles o_alu_stall=1 for one cycle, the rd=9 write occurs, the held ALU result writes on the next cycle, and the counter clears.
